// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch sequencer.
//   DATA_W            - width of the bus, address register and IR
//   HALT_WORD_DEFAULT - fetched word that stops sequencing
//   CNT_W             - width of the memory-ack wait counter
//   fetch_state_t     - sequencer state encoding
package fetch_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam logic [DATA_W-1:0] HALT_WORD_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_REQ    = 3'd2,
    ST_INC    = 3'd3,
    ST_VALID  = 3'd4,
    ST_HALTED = 3'd5,
    ST_ERROR  = 3'd6
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: 8-bit clear/increment wait counter for memory reads.
//   clk, reset (async, active-low)
//   clear   - force count to zero (has priority over inc)
//   inc     - add one to count
//   count   - current wait count
//   expired - this is the last permitted wait cycle; another cycle without
//             an ack would exceed TIMEOUT_CYCLES
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  // count holds the number of completed wait cycles, so the final allowed
  // cycle is the one where count equals TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count   = count_reg;
  assign expired = (count_reg == LAST_WAIT);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller between PC and decoder.
//   clk, reset (async, active-low)
//   run                  - permits starting / continuing fetches
//   bus_in               - shared bus, driven by the PC while pc_enable=1
//   pc_enable            - PC drives the bus (ADDR state)
//   pc_increment         - one-cycle PC advance after a non-HALT fetch
//   mem_addr/mem_req     - read request, address from the address register
//   mem_ack/mem_rdata    - read completion and data (same cycle)
//   ir/ir_valid/ir_ready - instruction register handshake to the decoder
//   halted               - sticky, HALT word fetched and consumed
//   fetch_error          - sticky, memory ack timeout
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [DATA_W-1:0] HALT_WORD      = HALT_WORD_DEFAULT,
  parameter int unsigned       TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] bus_in,
  output logic              pc_enable,
  output logic              pc_increment,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              halted,
  output logic              fetch_error
);

  fetch_state_t      state_reg, state_next;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] ir_reg;
  logic              halt_pending_reg;
  logic              wait_expired;
  logic              in_req;
  logic              ack_taken;
  logic [CNT_W-1:0]  wait_count;

  assign in_req    = (state_reg == ST_REQ);
  assign ack_taken = in_req && mem_ack;

  // The counter runs only while waiting in REQ; every other state, and the
  // accepting edge itself, return it to zero for the next fetch.
  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_req || mem_ack),
    .inc    (in_req && !mem_ack),
    .count  (wait_count),
    .expired(wait_expired)
  );

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:  if (run) state_next = ST_ADDR;
      ST_ADDR:  state_next = ST_REQ;
      ST_REQ: begin
        // An ack in the final permitted cycle wins over the timeout.
        if (mem_ack) begin
          state_next = (mem_rdata == HALT_WORD) ? ST_VALID : ST_INC;
        end else if (wait_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_INC:   state_next = ST_VALID;
      ST_VALID: begin
        if (ir_ready) begin
          if (halt_pending_reg) state_next = ST_HALTED;
          else if (run)         state_next = ST_ADDR;
          else                  state_next = ST_IDLE;
        end
      end
      ST_HALTED: state_next = ST_HALTED;
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ST_IDLE;
      addr_reg         <= '0;
      ir_reg           <= '0;
      halt_pending_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_ADDR) addr_reg <= bus_in;
      if (ack_taken) begin
        ir_reg <= mem_rdata;
        // A HALT skips INC so the PC keeps pointing at the HALT word.
        if (mem_rdata == HALT_WORD) halt_pending_reg <= 1'b1;
      end
    end
  end

  // Moore outputs decoded from the registered state.
  assign pc_enable    = (state_reg == ST_ADDR);
  assign mem_req      = in_req;
  assign pc_increment = (state_reg == ST_INC);
  assign ir_valid     = (state_reg == ST_VALID);
  assign halted       = (state_reg == ST_HALTED);
  assign fetch_error  = (state_reg == ST_ERROR);
  assign mem_addr     = addr_reg;
  assign ir           = ir_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] bus_in;
  logic        pc_enable, pc_increment, mem_req, ir_valid, halted, fetch_error;
  logic [15:0] mem_addr, ir;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        ir_ready = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // Memory / PC model controls
  logic [15:0] mem [0:63];
  logic [15:0] pc;
  logic [15:0] pc_init = 16'h0;
  int          lat = 0;
  logic        ack_en = 1'b1;
  logic        late_ack = 1'b0;
  int          req_cnt = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;
  logic [5:0]  strobes;

  assign strobes = {pc_enable, mem_req, pc_increment, ir_valid, halted, fetch_error};

  always #5 clk = ~clk;

  fetch_sequencer #(
    .HALT_WORD(16'hFFFF),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .bus_in(bus_in),
    .pc_enable(pc_enable), .pc_increment(pc_increment),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .halted(halted), .fetch_error(fetch_error)
  );

  // PC model: drives the bus only while enabled, advances on pc_increment.
  always @(posedge clk or negedge reset) begin
    if (!reset) pc <= pc_init;
    else if (pc_increment) pc <= pc + 16'd1;
  end
  assign bus_in = pc_enable ? pc : 16'hDEAD;

  // Memory model: ack after 'lat' wait cycles; the expected IR is queued
  // at the moment the ack is presented.
  always @(posedge clk) begin
    req_cnt <= (mem_req && !mem_ack) ? req_cnt + 1 : 0;
  end
  always @(negedge clk) begin
    mem_ack = late_ack || (mem_req && ack_en && req_cnt == lat);
    mem_rdata = late_ack ? 16'h5A5A : mem[mem_addr[5:0]];
    if (mem_ack && mem_req) exp_q.push_back(mem[mem_addr[5:0]]);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] init);
    pc_init = init;
    reset = 1'b0;
    run = 1'b0;
    ir_ready = 1'b0;
    late_ack = 1'b0;
    ack_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (strobes !== 6'b0 || ir !== 16'h0 || mem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs strobes=%b ir=%h addr=%h exp all zero", strobes, ir, mem_addr);
    end
    reset = 1'b1;
    tick; tick;
    n_checks++;
    if (strobes !== 6'b0) begin
      n_fail++;
      $display("FAIL idle_without_run strobes=%b exp=000000", strobes);
    end
    $display("test_reset done");
  endtask

  task automatic test_first_fetch;
    do_reset(16'h0000);
    lat = 1;
    run = 1'b1;
    tick;
    n_checks++;
    if (strobes !== 6'b100000) begin n_fail++; $display("FAIL ff_c1_addr strobes=%b exp=100000", strobes); end
    tick;
    n_checks++;
    if (strobes !== 6'b010000 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL ff_c2_req strobes=%b addr=%h exp=010000/0000", strobes, mem_addr); end
    tick;
    n_checks++;
    if (strobes !== 6'b010000 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL ff_c3_req strobes=%b addr=%h exp=010000/0000", strobes, mem_addr); end
    tick;
    n_checks++;
    if (strobes !== 6'b001000) begin n_fail++; $display("FAIL ff_c4_inc strobes=%b exp=001000", strobes); end
    tick;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (strobes !== 6'b000100 || ir !== exp_v || ir !== 16'h1234) begin
      n_fail++; $display("FAIL ff_c5_valid strobes=%b ir=%h exp=000100/%h", strobes, ir, exp_v);
    end
    ir_ready = 1'b1;
    run = 1'b0;
    tick;
    n_checks++;
    if (strobes !== 6'b0 || ir !== 16'h1234) begin n_fail++; $display("FAIL ff_idle strobes=%b ir=%h exp=000000/1234", strobes, ir); end
    $display("test_first_fetch done");
  endtask

  task automatic test_back_to_back;
    do_reset(16'h0000);
    lat = 0;
    ir_ready = 1'b1;
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++;
      if (strobes !== 6'b100000) begin n_fail++; $display("FAIL b2b_addr%0d strobes=%b exp=100000", k, strobes); end
      tick;
      n_checks++;
      if (strobes !== 6'b010000 || mem_addr !== 16'(k)) begin n_fail++; $display("FAIL b2b_req%0d strobes=%b addr=%h exp=010000/%0h", k, strobes, mem_addr, k); end
      tick;
      n_checks++;
      if (strobes !== 6'b001000) begin n_fail++; $display("FAIL b2b_inc%0d strobes=%b exp=001000", k, strobes); end
      if (k == 2) run = 1'b0;
      tick;
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      n_checks++;
      if (strobes !== 6'b000100 || ir !== exp_v) begin n_fail++; $display("FAIL b2b_valid%0d strobes=%b ir=%h exp=000100/%h", k, strobes, ir, exp_v); end
      $display("b2b fetch %0d addr=%0d ir=%h", k, k, ir);
    end
    tick;
    n_checks++;
    if (strobes !== 6'b0) begin n_fail++; $display("FAIL b2b_idle strobes=%b exp=000000", strobes); end
  endtask

  task automatic test_backpressure;
    logic [15:0] hold_v;
    do_reset(16'h0000);
    lat = 0;
    run = 1'b1;
    tick; tick; tick; tick;
    hold_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (strobes !== 6'b000100 || ir !== hold_v) begin n_fail++; $display("FAIL bp_valid strobes=%b ir=%h exp=000100/%h", strobes, ir, hold_v); end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++;
      if (strobes !== 6'b000100 || ir !== hold_v) begin n_fail++; $display("FAIL bp_hold%0d strobes=%b ir=%h exp=000100/%h", i, strobes, ir, hold_v); end
    end
    ir_ready = 1'b1;
    tick;
    n_checks++;
    if (strobes !== 6'b100000) begin n_fail++; $display("FAIL bp_next_addr strobes=%b exp=100000", strobes); end
    ir_ready = 1'b0;
    run = 1'b0;
    tick;
    n_checks++;
    if (strobes !== 6'b010000 || mem_addr !== 16'h1) begin n_fail++; $display("FAIL bp_req strobes=%b addr=%h exp=010000/0001", strobes, mem_addr); end
    tick; tick;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (strobes !== 6'b000100 || ir !== exp_v) begin n_fail++; $display("FAIL bp_valid2 strobes=%b ir=%h exp=000100/%h", strobes, ir, exp_v); end
    ir_ready = 1'b1;
    tick;
    n_checks++;
    if (strobes !== 6'b0) begin n_fail++; $display("FAIL bp_idle strobes=%b exp=000000", strobes); end
    $display("test_backpressure done");
  endtask

  task automatic test_halt;
    do_reset(16'h0003);
    lat = 0;
    run = 1'b1;
    tick;
    tick;
    n_checks++;
    if (strobes !== 6'b010000 || mem_addr !== 16'h3) begin n_fail++; $display("FAIL halt_req strobes=%b addr=%h exp=010000/0003", strobes, mem_addr); end
    tick;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (strobes !== 6'b000100 || ir !== exp_v || ir !== 16'hFFFF) begin n_fail++; $display("FAIL halt_valid_noinc strobes=%b ir=%h exp=000100/%h", strobes, ir, exp_v); end
    ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if (strobes !== 6'b000010) begin n_fail++; $display("FAIL halt_sticky%0d strobes=%b exp=000010", i, strobes); end
    end
    n_checks++;
    if (pc !== 16'h3) begin n_fail++; $display("FAIL halt_pc pc=%h exp=0003", pc); end
    $display("test_halt done");
  endtask

  task automatic test_timeout;
    do_reset(16'h0000);
    ack_en = 1'b0;
    run = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if (strobes !== 6'b010000) begin n_fail++; $display("FAIL to_req%0d strobes=%b exp=010000", i, strobes); end
    end
    tick;
    n_checks++;
    if (strobes !== 6'b000001) begin n_fail++; $display("FAIL to_error strobes=%b exp=000001", strobes); end
    late_ack = 1'b1;
    tick; tick;
    late_ack = 1'b0;
    n_checks++;
    if (strobes !== 6'b000001 || ir !== 16'h0) begin n_fail++; $display("FAIL to_late_ack strobes=%b ir=%h exp=000001/0000", strobes, ir); end
    ack_en = 1'b1;
    $display("test_timeout done");
  endtask

  task automatic test_reset_mid_req;
    do_reset(16'h0007);
    ack_en = 1'b0;
    run = 1'b1;
    tick; tick;
    n_checks++;
    if (strobes !== 6'b010000 || mem_addr !== 16'h7) begin n_fail++; $display("FAIL rst_pre strobes=%b addr=%h exp=010000/0007", strobes, mem_addr); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (strobes !== 6'b0 || mem_addr !== 16'h0 || ir !== 16'h0) begin n_fail++; $display("FAIL rst_async strobes=%b addr=%h ir=%h exp all zero", strobes, mem_addr, ir); end
    pc_init = 16'h0005;
    lat = 0;
    ack_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;
    tick;
    n_checks++;
    if (strobes !== 6'b100000) begin n_fail++; $display("FAIL rst_restart_addr strobes=%b exp=100000", strobes); end
    tick;
    n_checks++;
    if (strobes !== 6'b010000 || mem_addr !== 16'h5) begin n_fail++; $display("FAIL rst_restart_req strobes=%b addr=%h exp=010000/0005", strobes, mem_addr); end
    tick;
    run = 1'b0;
    tick;
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    n_checks++;
    if (strobes !== 6'b000100 || ir !== exp_v) begin n_fail++; $display("FAIL rst_restart_valid strobes=%b ir=%h exp=000100/%h", strobes, ir, exp_v); end
    $display("test_reset_mid_req done");
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[2] = 16'h9ABC;
    mem[3] = 16'hFFFF;
    mem[5] = 16'h0BEE;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_backpressure();
    test_halt();
    test_timeout();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller sitting between the program counter and the instruction decoder. It drives the PC's `enable` and `increment` controls and captures the PC value from the shared 16-bit bus into an internal address register. It then performs a req/ack memory read, loads the fetched word into the instruction register (IR), and hands it to the decoder with a valid/ready handshake. It also detects a HALT word and memory-ack timeouts.

## Interface
- `HALT_WORD`, default 16'hFFFF: fetched word that stops sequencing.
- `TIMEOUT_CYCLES`, default 16: max REQ cycles without `mem_ack` before error; legal range 2..255.
- `clk`  input  1  single clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state immediately.
- `run`  input  1  level; permits starting or continuing fetches.
- `bus_in`  input  16  shared bus (PC drives it while `pc_enable`=1).
- `pc_enable`  output  1  to PC `enable`; PC tristates onto bus.
- `pc_increment`  output  1  to PC `increment`; one-cycle pulse per fetch.
- `mem_addr`  output  16  read address (address register contents).
- `mem_req`  output  1  read request.
- `mem_ack`  input  1  read complete; `mem_rdata` valid same cycle.
- `mem_rdata`  input  16  read data.
- `ir`  output  16  instruction register.
- `ir_valid`  output  1  IR holds an unconsumed instruction.
- `ir_ready`  input  1  decoder accepts IR.
- `halted`  output  1  sticky; HALT word fetched and consumed.
- `fetch_error`  output  1  sticky; memory timeout.

## Operation
- States: IDLE, ADDR, REQ, INC, VALID, HALTED, ERROR.
- All outputs are Moore, decoded from registered state or driven directly from registers.
- IDLE: all strobes low. Goes to ADDR when `run`=1.
- ADDR: `pc_enable`=1. On the edge, `addr_reg <= bus_in`. Next state is REQ.
- REQ: `mem_req`=1; `mem_addr`=`addr_reg`, stable throughout.
  - On an edge with `mem_ack`=1: `ir <= mem_rdata`, wait counter clears. Next state is VALID if `mem_rdata`==`HALT_WORD` (a `halt_pending` flag is set), else INC.
  - Otherwise the wait counter increments. When the counter reaches `TIMEOUT_CYCLES` with no ack, the next state is ERROR.
- INC: `pc_increment`=1 for exactly one cycle. Next state is VALID.
- VALID: `ir_valid`=1; `ir` is held stable. On an edge with `ir_ready`=1:
  - `halt_pending` set: go to HALTED.
  - else `run`=1: go to ADDR.
  - else: go to IDLE.
- HALTED: `halted`=1, all strobes low. Exits only via reset.
- ERROR: `fetch_error`=1, all strobes low, `ir_valid`=0. Exits only via reset.
- `run` is sampled only in IDLE and on the VALID handshake. Deasserting `run` mid-fetch does not abort the fetch.
- A HALT word never causes a PC increment. The PC stays pointing at the HALT.
- `mem_ack` outside REQ is ignored. `ir_ready` outside VALID is ignored.
- `bus_in` is sampled only in ADDR.

## Timing
- Reset values: state=IDLE, `ir`=0, `addr_reg`=0 (so `mem_addr`=0), counter=0, `halt_pending`=0. All outputs are 0.
- Reset asserted mid-fetch: outputs drop immediately and asynchronously. No partial IR update survives.
- Cycle sequence, with `run` high at edge 0 and ack in the first REQ cycle: ADDR in cycle 1, REQ in cycle 2, INC in cycle 3, VALID in cycle 4.
- With `ir_ready` held high the steady loop is 4 cycles per instruction. Each extra cycle of ack latency adds one cycle.
- `pc_increment` rises the cycle after ack and precedes `ir_valid` by one cycle. The PC therefore holds the next address by the next ADDR.
- Timeout: REQ lasts exactly `TIMEOUT_CYCLES` cycles with no ack, then ERROR. An ack arriving in the last REQ cycle is accepted.
- Counter is 8 bits. It cannot wrap within the legal parameter range.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum `fetch_state_t` (one-hot encoding permitted);
  - `HALT_WORD_DEFAULT`;
  - the data/address width constant (16).
- Sub-module `fetch_timeout_ctr`: a clear/increment 8-bit counter with an `expired` compare against `TIMEOUT_CYCLES`.
- The FSM, the address register and the IR stay in the top module.

## Test plan
- Reset, then `run`=1 with the PC model driving 16'h0000 and memory returning 16'h1234 with one cycle of ack latency. Require:
  - `pc_enable` in cycle 1, `mem_addr`=0 and `mem_req` in cycles 2-3;
  - `pc_increment` pulse in cycle 4;
  - `ir_valid` with `ir`=16'h1234 in cycle 5.
- Three back-to-back fetches with `ir_ready` tied high. Require PC values 0, 1, 2 on `mem_addr` in turn and `ir_valid` every 4 cycles.
- Backpressure: hold `ir_ready`=0 for 5 cycles. Require that `ir` is held, no new `pc_enable`, and the next ADDR occurs the cycle after `ir_ready`=1.
- Memory returns 16'hFFFF at address 3. Require no `pc_increment`; after the handshake, `halted`=1 and all strobes stay low with `run` high.
- `mem_ack` never asserts with `TIMEOUT_CYCLES`=4. Require REQ for exactly 4 cycles, then `fetch_error`=1 and `mem_req`=0. A late ack has no effect.
- Assert reset during REQ. Require all outputs 0 immediately, and a clean restart from ADDR after release with `run`=1.
